// File: rtl/soc_addr_decode.sv
// Per-master request decoder in front of the SoC crossbar.
// Resolves AR/AW requests to a target and answers unmapped ones with DECERR.
module soc_addr_decode #(
    parameter int IdWidth        = 4,
    parameter int NbPeriph       = 9,
    parameter int EnableErrSlave = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [63:0]         req_addr_i,
    input  logic                req_write_i,
    input  logic [IdWidth-1:0]  req_id_i,
    input  logic [7:0]          req_len_i,
    output logic                dec_valid_o,
    input  logic                dec_ready_i,
    output logic [NbPeriph-1:0] dec_sel_o,
    output logic [3:0]          dec_idx_o,
    output logic                dec_err_o,
    output logic [63:0]         dec_addr_o,
    output logic                dec_write_o,
    output logic [IdWidth-1:0]  dec_id_o,
    output logic [7:0]          dec_len_o,
    output logic                err_valid_o,
    input  logic                err_ready_i,
    output logic                err_write_o,
    output logic [IdWidth-1:0]  err_id_o,
    output logic                err_last_o,
    output logic [1:0]          err_resp_o
);

    localparam logic [63:0] MapBase [9] = '{
        64'h0000_0000_8000_0000, 64'h0000_0000_4000_0000,
        64'h0000_0000_3000_0000, 64'h0000_0000_2000_0000,
        64'h0000_0000_1000_0000, 64'h0000_0000_0C00_0000,
        64'h0000_0000_0200_0000, 64'h0000_0000_0001_0000,
        64'h0000_0000_0000_0000
    };

    localparam logic [63:0] MapLen [9] = '{
        64'h0000_0000_4000_0000, 64'h0000_0000_0000_1000,
        64'h0000_0000_0001_0000, 64'h0000_0000_0080_0000,
        64'h0000_0000_0000_1000, 64'h0000_0000_03FF_FFFF,
        64'h0000_0000_000C_0000, 64'h0000_0000_0001_0000,
        64'h0000_0000_0000_1000
    };

    typedef enum logic {
        IDLE,
        ERR_RESP
    } state_t;

    state_t state_q, state_d;

    logic [NbPeriph-1:0] hit_sel;
    logic [3:0]          hit_idx;
    logic                hit;
    logic                accept;
    logic                load;
    logic                err_take;
    logic [7:0]          beat_q;
    logic [7:0]          err_len_q;
    logic                beat_inc;
    logic                beat_clr;

    // Regions are disjoint, so at most one bit of hit_sel is set.
    always_comb begin
        hit_sel = '0;
        hit_idx = '0;
        for (int i = 0; i < NbPeriph; i++) begin
            if (req_addr_i >= MapBase[i] &&
                req_addr_i < (MapBase[i] + MapLen[i])) begin
                hit_sel[i] = 1'b1;
                hit_idx    = i[3:0];
            end
        end
    end

    assign hit         = |hit_sel;
    assign req_ready_o = (state_q == IDLE) & (~dec_valid_o | dec_ready_i);
    assign accept      = req_valid_i & req_ready_o;
    assign load        = accept & (hit | (EnableErrSlave == 0));
    assign err_take    = accept & ~hit & (EnableErrSlave != 0);
    assign err_resp_o  = 2'b11;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dec_valid_o <= 1'b0;
            dec_sel_o   <= '0;
            dec_idx_o   <= '0;
            dec_err_o   <= 1'b0;
            dec_addr_o  <= '0;
            dec_write_o <= 1'b0;
            dec_id_o    <= '0;
            dec_len_o   <= '0;
        end else if (load) begin
            dec_valid_o <= 1'b1;
            dec_sel_o   <= hit_sel;
            dec_idx_o   <= hit_idx;
            dec_err_o   <= ~hit;
            dec_addr_o  <= req_addr_i;
            dec_write_o <= req_write_i;
            dec_id_o    <= req_id_i;
            dec_len_o   <= req_len_i;
        end else if (dec_valid_o && dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        err_valid_o = 1'b0;
        err_last_o  = 1'b0;
        beat_inc    = 1'b0;
        beat_clr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (err_take) begin
                    state_d = ERR_RESP;
                end
            end
            ERR_RESP: begin
                err_valid_o = 1'b1;
                err_last_o  = err_write_o | (beat_q == err_len_q);
                if (err_ready_i) begin
                    if (err_last_o) begin
                        state_d  = IDLE;
                        beat_clr = 1'b1;
                    end else begin
                        beat_inc = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only the failing request's response fields are kept; address is not needed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_write_o <= 1'b0;
            err_id_o    <= '0;
            err_len_q   <= '0;
            beat_q      <= '0;
        end else begin
            if (err_take) begin
                err_write_o <= req_write_i;
                err_id_o    <= req_id_i;
                err_len_q   <= req_len_i;
            end
            if (beat_clr) begin
                beat_q <= '0;
            end else if (beat_inc) begin
                beat_q <= beat_q + 8'd1;
            end
        end
    end

endmodule

// File: doc/soc_addr_decode.md
Name: soc_addr_decode

Overview:
- Request-side address decoder that sits directly upstream of the SoC crossbar slave ports, one instance per master.
- Registers each incoming AXI AR/AW request (address, direction, ID, burst length) and resolves it against the fixed SoC address map to a peripheral index and one-hot select.
- Requests to unmapped addresses are absorbed and answered locally with DECERR responses, so the crossbar never sees a request without a valid target.

Parameters:
- IdWidth, 4, request ID width; must equal the SoC master ID width.
- NbPeriph, 9, number of mapped targets, index 0..8.
- EnableErrSlave, 1, 1 = internal DECERR responder; 0 = unmapped requests forwarded with dec_err_o=1 and dec_sel_o=0.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  64  byte address
- req_write_i  in  1  1 = AW, 0 = AR
- req_id_i  in  IdWidth  AXI ID
- req_len_i  in  8  AXI len (beats-1)
- dec_valid_o  out  1  decoded request valid
- dec_ready_i  in  1  crossbar accepts decoded request
- dec_sel_o  out  NbPeriph  one-hot target select
- dec_idx_o  out  4  target index
- dec_err_o  out  1  unmapped (only when EnableErrSlave=0)
- dec_addr_o  out  64  registered address
- dec_write_o  out  1  registered direction
- dec_id_o  out  IdWidth  registered ID
- dec_len_o  out  8  registered len
- err_valid_o  out  1  error response beat valid (R or B)
- err_ready_i  in  1  response consumer ready
- err_write_o  out  1  1 = B response, 0 = R beat
- err_id_o  out  IdWidth  ID of the failing request
- err_last_o  out  1  last R beat (1 for B)
- err_resp_o  out  2  always 2'b11 (DECERR)

Behaviour:
- Reset (async, active-high): dec_valid_o=0, err_valid_o=0, err_last_o=0, dec_sel_o=0, dec_idx_o=0, dec_err_o=0, all data outputs 0, FSM=IDLE, beat counter=0. req_ready_o=1 after reset deasserts.
- Address map (hit when base <= addr < base+length, computed as 64-bit unsigned, no wrap):
  - idx 0 DRAM 0x8000_0000 / 0x4000_0000
  - idx 1 GPIO 0x4000_0000 / 0x1000
  - idx 2 Ethernet 0x3000_0000 / 0x1_0000
  - idx 3 SPI 0x2000_0000 / 0x80_0000
  - idx 4 UART 0x1000_0000 / 0x1000
  - idx 5 PLIC 0x0C00_0000 / 0x3FF_FFFF
  - idx 6 CLINT 0x0200_0000 / 0xC_0000
  - idx 7 ROM 0x1_0000 / 0x1_0000
  - idx 8 Debug 0x0 / 0x1000
  - Regions are disjoint. An exact end address (base+length) is a miss.
- Pipeline: a single output register stage with 1-cycle latency from acceptance to dec_valid_o.
  - req_ready_o = (state==IDLE) & (!dec_valid_o | dec_ready_i), giving full throughput when dec_ready_i is held high.
  - Decoded fields hold stable while dec_valid_o & !dec_ready_i.
  - dec_valid_o drops the cycle after a handshake unless a new request is accepted in the same cycle.
- FSM states:
  - IDLE: a mapped request loads the output register. An unmapped request with EnableErrSlave=1 is accepted but does not raise dec_valid_o; it captures id, write and len, then moves to ERR_RESP.
  - ERR_RESP: err_valid_o=1 and req_ready_o=0.
    - Write: one B beat, err_last_o=1, then return to IDLE on err_ready_i.
    - Read: len+1 R beats. The counter increments on each err_valid_o&err_ready_i. err_last_o=1 when counter==len. After the last handshake, clear the counter and return to IDLE.
    - len=255 gives 256 beats; the 8-bit counter does not wrap before last.
- A pending dec_valid_o in the output register must drain independently of ERR_RESP. ERR_RESP may overlap a stalled decoded request.
- Reset mid-burst: all state clears immediately, with no partial response completion.

Test Plan:
- Reset asserted mid-operation -> dec_valid_o=0, err_valid_o=0 asynchronously; req_ready_o=1 the first cycle after deassert.
- Back-to-back reads to 0x8000_0000, 0x1000_0000, 0x0001_0FFF with dec_ready_i=1 -> dec_idx_o 0, 4, 7 on consecutive cycles with one-hot dec_sel_o and one cycle of latency each.
- Boundaries: 0x0001_0000 -> idx 7; 0x0002_0000 -> unmapped; 0xBFFF_FFFF -> idx 0; 0xC000_0000 -> unmapped.
- Read at 0x5000_0000, id=3, len=3 -> exactly 4 R beats, err_id_o=3, err_resp_o=2'b11, err_last_o on beat 4 only; req_ready_o=0 throughout; random err_ready_i stalls hold the beat.
- Write at 0x0000_2000, id=5, len=7 -> exactly one B beat, err_last_o=1, err_id_o=5; return to IDLE the cycle after the handshake.
- dec_ready_i=0 for 5 cycles with a request to 0x4000_0000 -> outputs stable and req_ready_o=0; release -> handshake, then next request accepted in the same cycle.
